// File: rtl/mul_arbiter_if.sv
// Bundle between the round-robin multiplier arbiter and its surroundings:
// the requester lanes on one side and the shared `mul` instance on the other.
// master = requesters plus the attached multiplier, slave = the arbiter.
interface mul_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 25
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_in;
  logic [N*WIDTH-1:0] b_in;
  logic [N-1:0]       grant;
  logic [N-1:0]       res_done;
  logic [WIDTH-1:0]   res_val;
  logic               res_ovf;
  logic               res_err;
  logic               mul_rst;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_val;

  modport master (
    output req, a_in, b_in, mul_busy, mul_done, mul_ovf, mul_val,
    input  grant, res_done, res_val, res_ovf, res_err,
           mul_rst, mul_start, mul_a, mul_b
  );

  modport slave (
    input  req, a_in, b_in, mul_busy, mul_done, mul_ovf, mul_val,
    output grant, res_done, res_val, res_ovf, res_err,
           mul_rst, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fixed-point multiplier among N lanes.
// Captures the winner's operands, runs the start/done handshake, returns the
// product with a one-cycle done pulse and recovers a hung multiplier through
// a watchdog that pulses the multiplier reset.
module mul_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 25,
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst_n,
  mul_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    last;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic [WW-1:0]    wdog;
  logic             take_grant;
  logic             done_hit;
  logic             wdog_fire;
  logic             finish;

  logic [N-1:0]     grant_r;
  logic [N-1:0]     res_done_r;
  logic [WIDTH-1:0] res_val_r;
  logic             res_ovf_r;
  logic             res_err_r;
  logic             mul_rst_r;
  logic             mul_start_r;
  logic [WIDTH-1:0] mul_a_r;
  logic [WIDTH-1:0] mul_b_r;

  // mul_busy is observation only; the sink keeps it visible without driving logic
  logic unused_busy;
  assign unused_busy = bus.mul_busy;

  // Round-robin pick: first requesting lane scanning last+1, last+2, ... mod N
  always_comb begin
    logic [IW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_found) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (done_hit || wdog_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control strobes decoded from state; mul_done outside WAIT is ignored
  always_comb begin
    take_grant = (state == IDLE) && sel_found;
    done_hit   = (state == WAIT) && bus.mul_done;
    wdog_fire  = (state == WAIT) && !bus.mul_done && (wdog == WW'(TIMEOUT - 1));
    finish     = done_hit || wdog_fire;
  end

  // Registered datapath: operand capture, watchdog count and result return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last        <= IW'(N - 1);
      owner       <= '0;
      wdog        <= '0;
      grant_r     <= '0;
      res_done_r  <= '0;
      res_val_r   <= '0;
      res_ovf_r   <= 1'b0;
      res_err_r   <= 1'b0;
      mul_rst_r   <= 1'b1;
      mul_start_r <= 1'b0;
      mul_a_r     <= '0;
      mul_b_r     <= '0;
    end else begin
      res_done_r  <= '0;
      mul_start_r <= 1'b0;
      mul_rst_r   <= wdog_fire;
      if (take_grant) begin
        grant_r     <= N'(1) << sel_idx;
        owner       <= sel_idx;
        mul_a_r     <= bus.a_in[sel_idx*WIDTH +: WIDTH];
        mul_b_r     <= bus.b_in[sel_idx*WIDTH +: WIDTH];
        mul_start_r <= 1'b1;
      end
      if (state == ISSUE)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      if (finish) begin
        res_done_r <= grant_r;
        res_val_r  <= done_hit ? bus.mul_val : '0;
        res_ovf_r  <= done_hit ? bus.mul_ovf : 1'b0;
        res_err_r  <= !done_hit;
        last       <= owner;
        grant_r    <= '0;
      end
    end
  end

  assign bus.grant     = grant_r;
  assign bus.res_done  = res_done_r;
  assign bus.res_val   = res_val_r;
  assign bus.res_ovf   = res_ovf_r;
  assign bus.res_err   = res_err_r;
  assign bus.mul_rst   = mul_rst_r;
  assign bus.mul_start = mul_start_r;
  assign bus.mul_a     = mul_a_r;
  assign bus.mul_b     = mul_b_r;
endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter: directed requests with hand-computed Q4.21
// products, a scoreboard queue filled at stimulus time and drained by a
// monitor on every res_done pulse, plus a behavioural `mul` with a stuck mode.
module tb_mul_arbiter;
  localparam int N       = 4;
  localparam int W       = 25;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [N-1:0] done;
    logic [W-1:0] val;
    logic         ovf;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  mul_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  mul_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and edge counter used for latency expectations
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Q4.21 multiplier: done 4 cycles after the start cycle
  logic         m_done = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_busy = 1'b0;
  logic [W-1:0] m_val = '0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           m_cnt = 0;
  logic         stuck = 1'b0;
  logic         spur = 1'b0;

  function automatic logic [W:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    logic                  ovf;
    p   = $signed(a) * $signed(b);
    ovf = !((&p[2*W-1:2*W-5]) || !(|p[2*W-1:2*W-5]));
    return {ovf, p[45:21]};
  endfunction

  // Multiplier model pipeline
  always @(posedge clk) begin
    logic [W:0] r;
    m_done <= 1'b0;
    if (bus.mul_rst === 1'b1) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
    end else if (bus.mul_start === 1'b1) begin
      m_a    <= bus.mul_a;
      m_b    <= bus.mul_b;
      m_cnt  <= 3;
      m_busy <= 1'b1;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      if (!stuck) begin
        r      = qmul(m_a, m_b);
        m_done <= 1'b1;
        m_val  <= r[W-1:0];
        m_ovf  <= r[W];
      end
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (spur) begin
      m_done <= 1'b1;
      m_val  <= 25'h0155555;
      m_ovf  <= 1'b1;
    end
  end

  assign bus.mul_done = m_done;
  assign bus.mul_ovf  = m_ovf;
  assign bus.mul_val  = m_val;
  assign bus.mul_busy = m_busy;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setOperands(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[lane*W +: W] = a;
    bus.b_in[lane*W +: W] = b;
  endtask

  // Called at a negedge: raise req for one lane and queue its expected result
  task automatic applyStimulus(input int lane, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] val, input logic ovf, input logic err,
                               input int lat);
    exp_t e;
    setOperands(lane, a, b);
    bus.req[lane] = 1'b1;
    e.done = N'(1) << lane;
    e.val  = val;
    e.ovf  = ovf;
    e.err  = err;
    e.cyc  = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  // Bounded wait for a lane's done pulse, then drop its request
  task automatic waitDone(input int lane, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.res_done[lane]) seen = 1'b1;
    end
    bus.req[lane] = 1'b0;
    checkOutput($sformatf("done_seen_lane%0d", lane), 64'(seen), 64'd1);
  endtask

  // Monitor: every res_done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.res_done !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got %0h expected none (cycle %0d)", bus.res_done, cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("res_done", 64'(bus.res_done), 64'(mon_e.done));
        checkOutput("res_val", 64'(bus.res_val), 64'(mon_e.val));
        checkOutput("res_ovf", 64'(bus.res_ovf), 64'(mon_e.ovf));
        checkOutput("res_err", 64'(bus.res_err), 64'(mon_e.err));
        checkOutput("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Global time limit so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence
  initial begin
    int   n;
    int   k;
    exp_t e;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst_n    = 1'b0;
    @(negedge clk);

    // Reset held with all lanes requesting; lane operands for the fairness run
    bus.req = 4'b1111;
    setOperands(0, 25'h0300000, 25'h0400000);
    setOperands(1, 25'h0800000, 25'h0800000);
    setOperands(2, 25'h0100000, 25'h0100000);
    setOperands(3, 25'h1E00000, 25'h0400000);
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 64'(bus.grant), 64'd0);
    checkOutput("rst_res_done", 64'(bus.res_done), 64'd0);
    checkOutput("rst_mul_start", 64'(bus.mul_start), 64'd0);
    checkOutput("rst_mul_rst", 64'(bus.mul_rst), 64'd1);

    // Fairness: order 0,1,2,3,0,1,2,3 spaced 6 cycles apart
    k = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      e.done = N'(1) << (i % N);
      case (i % N)
        0:       begin e.val = 25'h0600000; e.ovf = 1'b0; end
        1:       begin e.val = 25'h0000000; e.ovf = 1'b1; end
        2:       begin e.val = 25'h0080000; e.ovf = 1'b0; end
        default: begin e.val = 25'h1C00000; e.ovf = 1'b0; end
      endcase
      e.err = 1'b0;
      e.cyc = k + 5 + 6 * i;
      sb.push_back(e);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_grant", 64'(bus.grant), 64'b0001);
    checkOutput("first_start", 64'(bus.mul_start), 64'd1);
    checkOutput("mul_rst_released", 64'(bus.mul_rst), 64'd0);
    @(negedge clk);
    checkOutput("start_one_cycle", 64'(bus.mul_start), 64'd0);
    checkOutput("grant_held", 64'(bus.grant), 64'b0001);
    n = 0;
    for (int i = 0; i < 100 && n < 8; i++) begin
      @(negedge clk);
      if (bus.res_done != '0) begin
        n++;
        if (n == 8) bus.req = '0;
      end
    end
    checkOutput("fair_count", 64'(n), 64'd8);
    repeat (2) @(negedge clk);

    // Single request on lane 2: 1.5 * 2.0 = 3.0; operands changed after grant
    applyStimulus(2, 25'h0300000, 25'h0400000, 25'h0600000, 1'b0, 1'b0, 5);
    @(negedge clk);
    checkOutput("single_grant", 64'(bus.grant), 64'b0100);
    checkOutput("single_start", 64'(bus.mul_start), 64'd1);
    setOperands(2, 25'h1FFFFFF, 25'h1FFFFFF);
    @(negedge clk);
    checkOutput("single_start_off", 64'(bus.mul_start), 64'd0);
    waitDone(2, 20);
    @(negedge clk);

    // Dropped request on lane 1 during WAIT: 0.5 * -2.0 = -1.0
    applyStimulus(1, 25'h0100000, 25'h1C00000, 25'h1E00000, 1'b0, 1'b0, 5);
    repeat (3) @(negedge clk);
    bus.req[1] = 1'b0;
    waitDone(1, 20);
    @(negedge clk);

    // Spurious mul_done while IDLE must be ignored
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    checkOutput("spur_mul_done", 64'(bus.mul_done), 64'd1);
    @(negedge clk);
    checkOutput("spur_ignored", 64'(bus.res_done), 64'd0);
    checkOutput("spur_no_grant", 64'(bus.grant), 64'd0);

    // Watchdog: mul never answers, error returned after TIMEOUT cycles in WAIT
    stuck = 1'b1;
    applyStimulus(0, 25'h0300000, 25'h0400000, 25'h0000000, 1'b0, 1'b1, TIMEOUT + 1);
    n = 0;
    for (int i = 0; i < 40 && n == 0; i++) begin
      @(negedge clk);
      if (bus.res_done[0]) n = 1;
    end
    checkOutput("wdog_done_seen", 64'(n), 64'd1);
    checkOutput("wdog_mul_rst", 64'(bus.mul_rst), 64'd1);
    bus.req[0] = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    checkOutput("wdog_mul_rst_pulse", 64'(bus.mul_rst), 64'd0);

    // Served normally after recovery: -1.0 * 2.0 = -2.0
    applyStimulus(3, 25'h1E00000, 25'h0400000, 25'h1C00000, 1'b0, 1'b0, 5);
    waitDone(3, 20);
    @(negedge clk);

    // Reset two cycles after ISSUE: in-flight result discarded
    setOperands(1, 25'h0300000, 25'h0400000);
    bus.req[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_res_done", 64'(bus.res_done), 64'd0);
    checkOutput("midrst_mul_rst", 64'(bus.mul_rst), 64'd1);
    checkOutput("midrst_grant", 64'(bus.grant), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e.done = 4'b0010;
    e.val  = 25'h0600000;
    e.ovf  = 1'b0;
    e.err  = 1'b0;
    e.cyc  = cyc + 6;
    sb.push_back(e);
    waitDone(1, 20);
    repeat (4) @(negedge clk);

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
